// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//  - Forwarding mux select codes (FWD_*)
//  - MULT/DIV tracker state encoding (md_state_e)
//  - reg_match(): register dependency test where register 0 never matches
package hazard_ctrl_pkg;

   localparam int unsigned REG_W = 5;
   localparam int unsigned FWD_W_BITS = 2;

   // Forwarding select codes for the Execute-stage operand muxes
   localparam logic [FWD_W_BITS-1:0] FWD_RF = 2'b00;
   localparam logic [FWD_W_BITS-1:0] FWD_W  = 2'b01;
   localparam logic [FWD_W_BITS-1:0] FWD_M  = 2'b10;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_e;

   // $zero is hard-wired, so a dependency on it is never real
   function automatic logic reg_match(input logic [REG_W-1:0] a,
                                      input logic [REG_W-1:0] b);
      return (a != '0) && (a == b);
   endfunction

endpackage

// File: rtl/hazard_ctrl_md_tracker.sv
// MULT/DIV occupancy tracker: FSM plus countdown.
// Ports:
//   CLK    in  clock, rising edge
//   RST    in  async reset, active high
//   start  in  an MD op issues from Decode this cycle
//   busy   out registered, high while HI/LO is being produced
module hazard_ctrl_md_tracker
   import hazard_ctrl_pkg::*;
#(
   parameter int unsigned MD_LATENCY = 32,
   parameter int unsigned CNT_W      = 6
) (
   input  logic CLK,
   input  logic RST,
   input  logic start,
   output logic busy
);

   md_state_e        state;
   logic [CNT_W-1:0] cnt;

   // Issue loads LATENCY-1 so busy stays high for exactly MD_LATENCY cycles
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= MD_IDLE;
         cnt   <= '0;
         busy  <= 1'b0;
      end else begin
         case (state)
            MD_IDLE: begin
               if (start) begin
                  state <= MD_BUSY;
                  cnt   <= CNT_W'(MD_LATENCY - 1);
                  busy  <= 1'b1;
               end
            end
            MD_BUSY: begin
               if (cnt == '0) begin
                  state <= MD_IDLE;
                  busy  <= 1'b0;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: begin
               state <= MD_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/scheduling controller for the 5-stage MIPS core.
// Produces forwarding selects, stall/flush controls for PC, F/D and D/E,
// and tracks the multi-cycle MULT/DIV unit.
// Ports:
//   CLK, RST                        clock / async active-high reset
//   RsD, RtD, RsE, RtE              source registers in Decode / Execute
//   WriteRegE/M/W, RegWriteE/M/W    destination register and enable per stage
//   MemtoRegE/M                     stage holds a load
//   BranchD, JumpRegD, TakenD       Decode control-flow info
//   MdStartD, MdReadD               Decode holds an MD op / HI-LO access
//   StallF, StallD, FlushD, FlushE  pipeline register controls
//   ForwardAD/BD, ForwardAE/BE      forwarding selects
//   MdBusy                          MD unit occupied (registered)
// Optional build macro HAZARD_PERF_EN adds StallCycles/FlushCycles counters.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int unsigned MD_LATENCY = 32,
   parameter int unsigned CNT_W      = 6
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [REG_W-1:0]      RsD,
   input  logic [REG_W-1:0]      RtD,
   input  logic [REG_W-1:0]      RsE,
   input  logic [REG_W-1:0]      RtE,
   input  logic [REG_W-1:0]      WriteRegE,
   input  logic [REG_W-1:0]      WriteRegM,
   input  logic [REG_W-1:0]      WriteRegW,
   input  logic                  RegWriteE,
   input  logic                  RegWriteM,
   input  logic                  RegWriteW,
   input  logic                  MemtoRegE,
   input  logic                  MemtoRegM,
   input  logic                  BranchD,
   input  logic                  JumpRegD,
   input  logic                  TakenD,
   input  logic                  MdStartD,
   input  logic                  MdReadD,
   output logic                  StallF,
   output logic                  StallD,
   output logic                  FlushD,
   output logic                  FlushE,
   output logic                  ForwardAD,
   output logic                  ForwardBD,
   output logic [FWD_W_BITS-1:0] ForwardAE,
   output logic [FWD_W_BITS-1:0] ForwardBE,
   output logic                  MdBusy
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0]           StallCycles,
   output logic [31:0]           FlushCycles
`endif
);

   logic lw_stall;
   logic br_stall;
   logic md_stall;
   logic stall;
   logic md_busy;

   // Forwarding and load/branch hazards are purely combinational
   always_comb begin
      lw_stall  = 1'b0;
      br_stall  = 1'b0;
      md_stall  = 1'b0;
      stall     = 1'b0;
      ForwardAE = FWD_RF;
      ForwardBE = FWD_RF;
      ForwardAD = 1'b0;
      ForwardBD = 1'b0;
      StallF    = 1'b0;
      StallD    = 1'b0;
      FlushD    = 1'b0;
      FlushE    = 1'b1;

      if (!RST) begin
         // Memory stage result is newer than writeback, so M wins
         if (RegWriteM && reg_match(WriteRegM, RsE))      ForwardAE = FWD_M;
         else if (RegWriteW && reg_match(WriteRegW, RsE)) ForwardAE = FWD_W;
         if (RegWriteM && reg_match(WriteRegM, RtE))      ForwardBE = FWD_M;
         else if (RegWriteW && reg_match(WriteRegW, RtE)) ForwardBE = FWD_W;

         ForwardAD = RegWriteM && reg_match(WriteRegM, RsD);
         ForwardBD = RegWriteM && reg_match(WriteRegM, RtD);

         lw_stall = MemtoRegE &&
                    (reg_match(WriteRegE, RsD) || reg_match(WriteRegE, RtD));

         // Branches compare Rs and Rt in Decode; jr/jalr only reads Rs
         br_stall = ((BranchD || JumpRegD) &&
                     ((RegWriteE && reg_match(WriteRegE, RsD)) ||
                      (MemtoRegM && reg_match(WriteRegM, RsD)))) ||
                    (BranchD &&
                     ((RegWriteE && reg_match(WriteRegE, RtD)) ||
                      (MemtoRegM && reg_match(WriteRegM, RtD))));

         md_stall = md_busy && (MdStartD || MdReadD);

         stall  = lw_stall || br_stall || md_stall;
         StallF = stall;
         StallD = stall;
         FlushE = stall;
         // A stalled branch gets re-evaluated next cycle, so do not flush yet
         FlushD = TakenD && !stall;
      end
   end

   hazard_ctrl_md_tracker #(
      .MD_LATENCY (MD_LATENCY),
      .CNT_W      (CNT_W)
   ) u_md_tracker (
      .CLK   (CLK),
      .RST   (RST),
      .start (MdStartD && !stall),
      .busy  (md_busy)
   );

   assign MdBusy = md_busy;

`ifdef HAZARD_PERF_EN
   // Saturating event counters for stall and front-end flush cycles
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         StallCycles <= '0;
         FlushCycles <= '0;
      end else begin
         if (stall && (StallCycles != 32'hFFFF_FFFF))
            StallCycles <= StallCycles + 32'd1;
         if (FlushD && (FlushCycles != 32'hFFFF_FFFF))
            FlushCycles <= FlushCycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MD_LATENCY = 4).
module tb_hazard_ctrl;

   logic       CLK;
   logic       RST;
   logic [4:0] RsD, RtD, RsE, RtE;
   logic [4:0] WriteRegE, WriteRegM, WriteRegW;
   logic       RegWriteE, RegWriteM, RegWriteW;
   logic       MemtoRegE, MemtoRegM;
   logic       BranchD, JumpRegD, TakenD;
   logic       MdStartD, MdReadD;
   logic       StallF, StallD, FlushD, FlushE;
   logic       ForwardAD, ForwardBD;
   logic [1:0] ForwardAE, ForwardBE;
   logic       MdBusy;
`ifdef HAZARD_PERF_EN
   logic [31:0] StallCycles, FlushCycles;
`endif

   int tests = 0;
   int fails = 0;

   hazard_ctrl #(.MD_LATENCY(4), .CNT_W(6)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .RsD       (RsD),
      .RtD       (RtD),
      .RsE       (RsE),
      .RtE       (RtE),
      .WriteRegE (WriteRegE),
      .WriteRegM (WriteRegM),
      .WriteRegW (WriteRegW),
      .RegWriteE (RegWriteE),
      .RegWriteM (RegWriteM),
      .RegWriteW (RegWriteW),
      .MemtoRegE (MemtoRegE),
      .MemtoRegM (MemtoRegM),
      .BranchD   (BranchD),
      .JumpRegD  (JumpRegD),
      .TakenD    (TakenD),
      .MdStartD  (MdStartD),
      .MdReadD   (MdReadD),
      .StallF    (StallF),
      .StallD    (StallD),
      .FlushD    (FlushD),
      .FlushE    (FlushE),
      .ForwardAD (ForwardAD),
      .ForwardBD (ForwardBD),
      .ForwardAE (ForwardAE),
      .ForwardBE (ForwardBE),
      .MdBusy    (MdBusy)
`ifdef HAZARD_PERF_EN
      ,
      .StallCycles (StallCycles),
      .FlushCycles (FlushCycles)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic clr();
      RsD = 0; RtD = 0; RsE = 0; RtE = 0;
      WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
      RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
      MemtoRegE = 0; MemtoRegM = 0;
      BranchD = 0; JumpRegD = 0; TakenD = 0;
      MdStartD = 0; MdReadD = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      clr();
      RST = 1'b1;
      // Hazards present during reset must be masked
      TakenD = 1; RegWriteM = 1; WriteRegM = 8; RsE = 8;
      MemtoRegE = 1; WriteRegE = 9; RtD = 9;
      #1;
      check("rst_stallf", 32'(StallF), 32'd0);
      check("rst_stalld", 32'(StallD), 32'd0);
      check("rst_flushd", 32'(FlushD), 32'd0);
      check("rst_flushe", 32'(FlushE), 32'd1);
      check("rst_fwdae",  32'(ForwardAE), 32'd0);
      check("rst_mdbusy", 32'(MdBusy), 32'd0);
      step();
      RST = 1'b0;
      clr();
      #1;
      check("idle_flushe", 32'(FlushE), 32'd0);
      check("idle_stallf", 32'(StallF), 32'd0);

      // Forwarding priority: M beats W
      RegWriteM = 1; WriteRegM = 8; RegWriteW = 1; WriteRegW = 8; RsE = 8;
      #1;
      check("fwd_ae_m", 32'(ForwardAE), 32'd2);
      RegWriteM = 0;
      #1;
      check("fwd_ae_w", 32'(ForwardAE), 32'd1);
      RtE = 8; RsE = 3;
      #1;
      check("fwd_be_w", 32'(ForwardBE), 32'd1);
      check("fwd_ae_rf", 32'(ForwardAE), 32'd0);
      RegWriteM = 1; WriteRegM = 0; RegWriteW = 1; WriteRegW = 0; RsE = 0; RtE = 0;
      #1;
      check("fwd_r0_ae", 32'(ForwardAE), 32'd0);
      check("fwd_r0_be", 32'(ForwardBE), 32'd0);
      WriteRegM = 7; RsD = 7; RtD = 6;
      #1;
      check("fwd_ad", 32'(ForwardAD), 32'd1);
      check("fwd_bd", 32'(ForwardBD), 32'd0);
      clr();

      // Load-use stall and register-0 exemption
      MemtoRegE = 1; WriteRegE = 9; RtD = 9;
      #1;
      check("lw_stallf", 32'(StallF), 32'd1);
      check("lw_stalld", 32'(StallD), 32'd1);
      check("lw_flushe", 32'(FlushE), 32'd1);
      WriteRegE = 0; RtD = 0;
      #1;
      check("lw_r0", 32'(StallD), 32'd0);
      clr();

      // Branch dependent on Execute result: stall, no flush, then flush
      BranchD = 1; TakenD = 1; RegWriteE = 1; WriteRegE = 4; RsD = 4;
      #1;
      check("br_stall", 32'(StallD), 32'd1);
      check("br_flushd0", 32'(FlushD), 32'd0);
      step();
      RegWriteE = 0;
      #1;
      check("br_flushd1", 32'(FlushD), 32'd1);
      check("br_nostall", 32'(StallD), 32'd0);
      // jr ignores Rt dependency; load in M on Rs stalls it
      clr();
      JumpRegD = 1; RegWriteE = 1; WriteRegE = 5; RtD = 5; RsD = 6;
      #1;
      check("jr_rt_ignored", 32'(StallD), 32'd0);
      MemtoRegM = 1; WriteRegM = 6;
      #1;
      check("jr_lw_m", 32'(StallD), 32'd1);
      clr();

      // MD op: busy 4 cycles, MdReadD stalled exactly that long
      MdStartD = 1;
      #1;
      check("md_issue_nostall", 32'(StallD), 32'd0);
      step();
      MdStartD = 0; MdReadD = 1;
      #1;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("md_busy_%0d", i), 32'(MdBusy), 32'd1);
         check($sformatf("md_stall_%0d", i), 32'(StallD), 32'd1);
         step();
      end
      check("md_done_busy", 32'(MdBusy), 32'd0);
      check("md_done_stall", 32'(StallD), 32'd0);
      clr();

      // Reset in the middle of an MD op
      MdStartD = 1;
      step();
      MdStartD = 0;
      step();
      step();
      check("mdrst_pre", 32'(MdBusy), 32'd1);
      RST = 1;
      #1;
      check("mdrst_busy", 32'(MdBusy), 32'd0);
      check("mdrst_flushe", 32'(FlushE), 32'd1);
      step();
      RST = 0;
      MdReadD = 1;
      #1;
      check("mdrst_read_nostall", 32'(StallD), 32'd0);
      step();
      check("mdrst_read_nostall2", 32'(StallD), 32'd0);
      clr();

`ifdef HAZARD_PERF_EN
      RST = 1;
      #1;
      check("perf_rst_stall", StallCycles, 32'd0);
      check("perf_rst_flush", FlushCycles, 32'd0);
      step();
      RST = 0;
      MemtoRegE = 1; WriteRegE = 9; RsD = 9;
      step();
      step();
      step();
      clr();
      TakenD = 1;
      step();
      step();
      clr();
      step();
      check("perf_stall", StallCycles, 32'd3);
      check("perf_flush", FlushCycles, 32'd2);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
